rvc_aligner: RTL
================

Name: rvc_aligner

Overview:
- Halfword realignment buffer between the fetch interface and the compressed/full instruction decoders.
- Accepts aligned fetch words of FETCH_HW halfwords and buffers them as halfwords.
- Emits one complete instruction per handshake: 16-bit when low bits != 2'b11, otherwise 32-bit, including 32-bit instructions split across two fetch words.
- Tracks the instruction PC, supports redirect flush, and propagates fetch bus errors.

Parameters:
FETCH_HW, 2, halfwords per fetch word (fetch data width = 16*FETCH_HW); power of two, >= 1
DEPTH_HW, 6, buffer capacity in halfwords; >= FETCH_HW+1
ADDR_W, 32, PC width
BOOT_ADDR, 32'h0000_0000, PC loaded at reset; bit 0 ignored

Ports:
s_clk_i  in  1  clock
s_reset_i  in  1  asynchronous active-high reset
s_flush_i  in  1  redirect; discards buffer contents
s_flush_addr_i  in  ADDR_W  new PC on flush
s_fetch_valid_i  in  1  fetch word valid
s_fetch_ready_o  out  1  buffer can accept a fetch word
s_fetch_data_i  in  16*FETCH_HW  fetch word; halfword 0 at lowest address
s_fetch_err_i  in  1  bus error for the whole fetch word
s_instr_valid_o  out  1  complete instruction at head
s_instr_ready_i  in  1  consumer takes instruction
s_instr_o  out  32  instruction; upper 16 bits zero when rvc
s_instr_rvc_o  out  1  instruction is compressed
s_instr_err_o  out  1  fetch error on any halfword of the instruction
s_instr_pc_o  out  ADDR_W  PC of instruction

Behaviour:
- Clock and reset: one clock s_clk_i; reset s_reset_i is asynchronous and active-high.
- State:
  - halfword array with per-halfword error bit
  - count 0..DEPTH_HW
  - pc register
  - skip counter 0..FETCH_HW-1
- Reset values:
  - count=0, skip=0, pc=BOOT_ADDR with bit0 cleared
  - s_instr_valid_o=0, s_fetch_ready_o=1
  - s_instr_o=0, s_instr_rvc_o=0, s_instr_err_o=0, s_instr_pc_o=BOOT_ADDR with bit0 cleared
- s_fetch_ready_o = (DEPTH_HW - count >= FETCH_HW). It is a function of registered count only; no combinational path from s_instr_ready_i.
- Push (s_fetch_valid_i & s_fetch_ready_o & ~s_flush_i):
  - Append halfwords skip..FETCH_HW-1 in ascending order.
  - Each appended halfword gets error bit = s_fetch_err_i.
  - skip then returns to 0.
- Head decode, combinational from registered array:
  - hw0 low bits != 11 and count>=1: valid, rvc=1, size 1.
  - hw0 low bits == 11 and count>=2: valid, rvc=0, instr={hw1,hw0}, err=err0|err1, size 2.
  - hw0 low bits == 11, count==1, err0=1: valid, rvc=0, err=1, instr={16'b0,hw0}, size 1. This prevents deadlock on an erroring fetch.
  - Otherwise valid=0 and s_instr_o/rvc/err are 0.
- Pop (s_instr_valid_o & s_instr_ready_i & ~s_flush_i):
  - Remove size halfwords, shift remaining toward head.
  - pc += 2*size, modulo 2^ADDR_W (wraps).
- Push and pop in the same cycle are both applied: new count = count - size + pushed. Head shift and append compose correctly.
- Latency: a halfword pushed in cycle N is visible at the outputs in cycle N+1. The buffer has no bypass.
- Flush:
  - Highest priority; the same-cycle push and pop are discarded.
  - Next cycle: count=0, pc=s_flush_addr_i with bit0 cleared.
  - skip = s_flush_addr_i[log2(FETCH_HW):1], so the first fetch after a flush drops leading halfwords below the target.
  - When FETCH_HW=1, skip is always 0.
  - The fetch unit guarantees the next word accepted after a flush is the word containing the flush target.
- Valid/ready rules:
  - s_instr_valid_o, once asserted, stays asserted with stable data until popped or flushed.
  - The instruction may change from "waiting for upper half" to valid only on a push.
- Reset mid-operation clears all state immediately, asynchronously.

Test Plan:
- Reset, then idle: s_instr_valid_o=0, s_fetch_ready_o=1, s_instr_pc_o=0.
- Push 32'h00A5_0513, hold s_instr_ready_i=1:
  - next cycle valid=1, instr=32'h00A50513, rvc=0, pc=0
  - after pop pc=4, valid=0.
- Push 32'h4101_4501:
  - cycle 1: instr=32'h00004501, rvc=1, pc=0
  - cycle 2: instr=32'h00004101, pc=2
  - then valid=0, pc=4.
- Flush to 0x102, then push 32'h0513_xxxx:
  - valid stays 0 (count=1, low bits 11).
  - Push 32'hxxxx_00A5: instr=32'h00A50513, pc=0x102, rvc=0.
- Backpressure, DEPTH_HW=6, instr_ready=0, three pushes of 32'h4501_4501:
  - ready=0 at count=6.
  - One rvc pop leaves count=5, ready stays 0.
  - A second pop leaves count=4, ready=1.
- Error handling:
  - Flush to 0x2, push 32'h0003_xxxx with err=1: valid=1, err=1, instr=32'h00000003; pop gives pc=0x4.
  - Flush asserted together with a push and a pop: neither is applied; count=0, pc=flush target.

Source files
------------

// File: rtl/rvc_aligner.sv
// Halfword realignment buffer: turns aligned fetch words into whole 16/32-bit instructions with PC and error.
// Head outputs decode combinationally from registered state; fetch ready depends only on registered count.
module rvc_aligner #(
  parameter int                FETCH_HW  = 2,
  parameter int                DEPTH_HW  = 6,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BOOT_ADDR = '0
) (
  input  logic                    s_clk_i,
  input  logic                    s_reset_i,
  input  logic                    s_flush_i,
  input  logic [ADDR_W-1:0]       s_flush_addr_i,
  input  logic                    s_fetch_valid_i,
  output logic                    s_fetch_ready_o,
  input  logic [16*FETCH_HW-1:0]  s_fetch_data_i,
  input  logic                    s_fetch_err_i,
  output logic                    s_instr_valid_o,
  input  logic                    s_instr_ready_i,
  output logic [31:0]             s_instr_o,
  output logic                    s_instr_rvc_o,
  output logic                    s_instr_err_o,
  output logic [ADDR_W-1:0]       s_instr_pc_o
);

  localparam int CW = $clog2(DEPTH_HW + 1);
  localparam int SW = (FETCH_HW > 1) ? $clog2(FETCH_HW) : 1;

  logic [15:0]         hw_q [DEPTH_HW];
  logic [15:0]         hw_d [DEPTH_HW];
  logic [DEPTH_HW-1:0] err_q, err_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [SW-1:0]       skip_q, skip_d;

  logic [1:0] head_sz;
  logic [1:0] pop_sz;
  logic       push, pop;
  int         base;

  assign s_fetch_ready_o = (DEPTH_HW - int'(cnt_q)) >= FETCH_HW;
  assign s_instr_pc_o    = pc_q;

  always_comb begin
    s_instr_valid_o = 1'b0;
    s_instr_o       = '0;
    s_instr_rvc_o   = 1'b0;
    s_instr_err_o   = 1'b0;
    head_sz         = 2'd0;
    if (cnt_q != '0) begin
      if (hw_q[0][1:0] != 2'b11) begin
        s_instr_valid_o = 1'b1;
        s_instr_rvc_o   = 1'b1;
        s_instr_o       = {16'h0000, hw_q[0]};
        s_instr_err_o   = err_q[0];
        head_sz         = 2'd1;
      end else if (int'(cnt_q) >= 2) begin
        s_instr_valid_o = 1'b1;
        s_instr_o       = {hw_q[1], hw_q[0]};
        s_instr_err_o   = err_q[0] | err_q[1];
        head_sz         = 2'd2;
      end else if (err_q[0]) begin
        // Upper half will never be trustworthy; release the lone erroring halfword.
        s_instr_valid_o = 1'b1;
        s_instr_o       = {16'h0000, hw_q[0]};
        s_instr_err_o   = 1'b1;
        head_sz         = 2'd1;
      end
    end
  end

  assign push   = s_fetch_valid_i & s_fetch_ready_o & ~s_flush_i;
  assign pop    = s_instr_valid_o & s_instr_ready_i & ~s_flush_i;
  assign pop_sz = pop ? head_sz : 2'd0;

  always_comb begin
    base   = int'(cnt_q) - int'(pop_sz);
    err_d  = '0;
    for (int i = 0; i < DEPTH_HW; i++) begin
      hw_d[i] = '0;
      if (i + int'(pop_sz) < DEPTH_HW) begin
        hw_d[i]  = hw_q[i + int'(pop_sz)];
        err_d[i] = err_q[i + int'(pop_sz)];
      end
    end
    if (push) begin
      for (int k = 0; k < FETCH_HW; k++) begin
        if (k >= int'(skip_q) && (base + k - int'(skip_q)) < DEPTH_HW) begin
          hw_d[base + k - int'(skip_q)]  = s_fetch_data_i[16*k +: 16];
          err_d[base + k - int'(skip_q)] = s_fetch_err_i;
        end
      end
    end
    cnt_d  = CW'(base + (push ? (FETCH_HW - int'(skip_q)) : 0));
    pc_d   = pc_q + ADDR_W'({pop_sz, 1'b0});
    skip_d = push ? '0 : skip_q;
    if (s_flush_i) begin
      cnt_d  = '0;
      pc_d   = {s_flush_addr_i[ADDR_W-1:1], 1'b0};
      skip_d = SW'((s_flush_addr_i >> 1) & ADDR_W'(FETCH_HW - 1));
    end
  end

  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) begin
      cnt_q  <= '0;
      skip_q <= '0;
      pc_q   <= {BOOT_ADDR[ADDR_W-1:1], 1'b0};
      err_q  <= '0;
      for (int i = 0; i < DEPTH_HW; i++) hw_q[i] <= '0;
    end else begin
      cnt_q  <= cnt_d;
      skip_q <= skip_d;
      pc_q   <= pc_d;
      err_q  <= err_d;
      hw_q   <= hw_d;
    end
  end

endmodule
